// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port synchronous RAM between the CPU
//             instruction-fetch port and the CPU data port. Each requester
//             holds req until a one-cycle valid pulse. Accesses are
//             serialised IDLE -> ACCESS -> WAIT -> DONE with round-robin
//             arbitration between the two ports. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int AW      = 32,   // word address width
   parameter int DW      = 32,   // data width
   parameter int LATENCY = 1     // RAM read latency after the mem_en cycle, 1..15
) (
   input  logic          clk,
   input  logic          reset,

   // instruction fetch port (read only)
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_valid,

   // data port
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,

   // memory side
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,

   output logic          busy
);

   // -------------------------------------------------------------------------
   // Encodings
   // -------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic       OWNER_I = 1'b0;
   localparam logic       OWNER_D = 1'b1;

   // WAIT-phase down-counter start value; 4 bits covers the legal 1..15 range
   localparam logic [3:0] LAT_CNT = 4'(LATENCY);

   // -------------------------------------------------------------------------
   // State and registered outputs
   // -------------------------------------------------------------------------
   state_t          state_q,      state_d;
   logic            owner_q,      owner_d;       // port being served
   logic            last_owner_q, last_owner_d;  // port served most recently
   logic            we_q,         we_d;          // latched direction of access
   logic [3:0]      cnt_q,        cnt_d;         // WAIT cycles remaining

   logic            mem_en_q,     mem_en_d;
   logic            mem_we_q,     mem_we_d;
   logic [AW-1:0]   mem_addr_q,   mem_addr_d;
   logic [DW-1:0]   mem_wdata_q,  mem_wdata_d;
   logic [DW-1:0]   i_rdata_q,    i_rdata_d;
   logic [DW-1:0]   d_rdata_q,    d_rdata_d;
   logic            i_valid_q,    i_valid_d;
   logic            d_valid_q,    d_valid_d;
   logic            busy_q,       busy_d;

   // -------------------------------------------------------------------------
   // Arbitration: a lone request wins outright; when both ports ask, the
   // port that was not served last wins, giving strict alternation.
   // -------------------------------------------------------------------------
   logic w_any_req;
   logic w_grant_data;

   assign w_any_req    = i_req | d_req;
   assign w_grant_data = d_req & (~i_req | (last_owner_q == OWNER_I));

   // Next-state and next-output computation for the access sequencer
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      busy_d       = busy_q;
      // strobes and pulses are single-cycle, so they default low
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      i_valid_d    = 1'b0;
      d_valid_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_any_req) begin
               // latch everything the RAM needs now; later input changes
               // from the requester must not reach the memory bus
               if (w_grant_data) begin
                  owner_d     = OWNER_D;
                  we_d        = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end else begin
                  owner_d     = OWNER_I;
                  we_d        = 1'b0;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = '0;
               end
               last_owner_d = w_grant_data ? OWNER_D : OWNER_I;
               // strobe is registered, so it is raised for the ACCESS cycle
               mem_en_d     = 1'b1;
               mem_we_d     = w_grant_data ? d_we : 1'b0;
               busy_d       = 1'b1;
               state_d      = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            cnt_d   = LAT_CNT;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               // read data is on mem_rdata during this last WAIT cycle;
               // writes leave both rdata registers untouched
               if (!we_q) begin
                  if (owner_q == OWNER_D) begin
                     d_rdata_d = mem_rdata;
                  end else begin
                     i_rdata_d = mem_rdata;
                  end
               end
               i_valid_d = (owner_q == OWNER_I);
               d_valid_d = (owner_q == OWNER_D);
               state_d   = ST_DONE;
            end
         end

         ST_DONE: begin
            // requests are ignored here; arbitration resumes in IDLE
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Register bank; reset abandons any access in flight without a valid pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWNER_I;
         last_owner_q <= OWNER_D;   // first contested grant goes to fetch
         we_q         <= 1'b0;
         cnt_q        <= 4'd0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         i_valid_q    <= 1'b0;
         d_valid_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         i_valid_q    <= i_valid_d;
         d_valid_q    <= d_valid_d;
         busy_q       <= busy_d;
      end
   end

   // -------------------------------------------------------------------------
   // Output drive
   // -------------------------------------------------------------------------
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = i_rdata_q;
   assign i_valid   = i_valid_q;
   assign d_rdata   = d_rdata_q;
   assign d_valid   = d_valid_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Two instances
//             (LATENCY 1 and 3), each with its own RAM model and a
//             transaction-timeline reference model checked every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   logic        clk;
   logic        reset     [2];
   logic        i_req     [2];
   logic [31:0] i_addr    [2];
   logic [31:0] i_rdata   [2];
   logic        i_valid   [2];
   logic        d_req     [2];
   logic        d_we      [2];
   logic [31:0] d_addr    [2];
   logic [31:0] d_wdata   [2];
   logic [31:0] d_rdata   [2];
   logic        d_valid   [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        busy      [2];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   generate
      for (genvar k = 0; k < 2; k++) begin : g_dut
         mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(k == 0 ? 1 : 3)) u_dut (
            .clk(clk), .reset(reset[k]),
            .i_req(i_req[k]), .i_addr(i_addr[k]), .i_rdata(i_rdata[k]), .i_valid(i_valid[k]),
            .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
            .d_rdata(d_rdata[k]), .d_valid(d_valid[k]),
            .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
            .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]), .busy(busy[k])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic void chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL k%0d %s cycle=%0d actual=%h required=%h", k, nm, cyc, act, exp);
      end
   endfunction

   function automatic void chkb(input int k, input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL k%0d %s cycle=%0d actual=%b required=%b", k, nm, cyc, act, exp);
      end
   endfunction

   // ------------------------------------------------------------------------
   // RAM model: writes commit on a write strobe, read data appears exactly
   // LATENCY cycles after the strobe cycle; every other cycle carries a
   // cycle-dependent junk word so a mistimed capture is visible.
   // ------------------------------------------------------------------------
   logic [31:0] mem [logic [32:0]];
   int          due   [2];
   logic [31:0] paddr [2];

   function automatic logic [31:0] memval(input int k, input logic [31:0] a);
      logic [32:0] key;
      key = {1'(k), a};
      if (mem.exists(key)) return mem[key];
      return 32'h5A00_0000 ^ a;
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         if (cyc == due[k]) mem_rdata[k] = memval(k, paddr[k]);
         else               mem_rdata[k] = 32'hBAD0_0000 ^ cyc;
      end
   end

   // ------------------------------------------------------------------------
   // Reference model: a grant at cycle g puts mem_en in g+1, the capture in
   // g+1+L, the owner's valid in g+2+L and the next free IDLE at g+3+L.
   // ------------------------------------------------------------------------
   bit          ok    [2];
   bit          act   [2];
   int          g     [2];
   logic        owner [2];
   logic        last  [2];
   logic        mwe   [2];
   logic [31:0] maddr [2];
   logic [31:0] mwd   [2];
   logic [31:0] eir   [2];
   logic [31:0] edr   [2];
   logic [31:0] emad  [2];

   logic [31:0] aq [2][$];   // mem_addr at each strobe
   int          ac [2][$];   // cycle of each strobe
   logic        vq [2][$];   // which port pulsed valid
   int          vc [2][$];   // cycle of each valid pulse

   always @(negedge clk) begin
      int   L;
      logic e_busy, e_en, e_iv, e_dv, own;
      for (int k = 0; k < 2; k++) begin
         L = lat_of(k);
         if (ok[k]) begin
            e_busy = act[k] && (cyc >= g[k] + 1) && (cyc <= g[k] + 2 + L);
            e_en   = act[k] && (cyc == g[k] + 1);
            e_iv   = act[k] && (cyc == g[k] + 2 + L) && (owner[k] == OWN_I);
            e_dv   = act[k] && (cyc == g[k] + 2 + L) && (owner[k] == OWN_D);
            chkb(k, "busy",    busy[k],    e_busy);
            chkb(k, "mem_en",  mem_en[k],  e_en);
            chkb(k, "i_valid", i_valid[k], e_iv);
            chkb(k, "d_valid", d_valid[k], e_dv);
            chk (k, "i_rdata", i_rdata[k], eir[k]);
            chk (k, "d_rdata", d_rdata[k], edr[k]);
            chk (k, "mem_addr", mem_addr[k], emad[k]);
            if (e_en) begin
               chkb(k, "mem_we", mem_we[k], mwe[k]);
               if (mwe[k]) chk(k, "mem_wdata", mem_wdata[k], mwd[k]);
            end
         end

         if (i_valid[k] === 1'b1) begin vq[k].push_back(OWN_I); vc[k].push_back(cyc); end
         if (d_valid[k] === 1'b1) begin vq[k].push_back(OWN_D); vc[k].push_back(cyc); end
         if (mem_en[k] === 1'b1) begin
            aq[k].push_back(mem_addr[k]);
            ac[k].push_back(cyc);
            if (mem_we[k]) mem[{1'(k), mem_addr[k]}] = mem_wdata[k];
            else begin due[k] = cyc + L; paddr[k] = mem_addr[k]; end
         end

         if (reset[k]) begin
            ok[k] = 1'b1; act[k] = 1'b0; last[k] = OWN_D;
            eir[k] = '0; edr[k] = '0; emad[k] = '0;
         end else if (ok[k]) begin
            if (act[k] && (cyc == g[k] + 1 + L) && !mwe[k]) begin
               if (owner[k] == OWN_I) eir[k] = memval(k, maddr[k]);
               else                   edr[k] = memval(k, maddr[k]);
            end
            if (!act[k] || (cyc >= g[k] + 3 + L)) begin
               if (i_req[k] || d_req[k]) begin
                  if (i_req[k] && d_req[k]) own = (last[k] == OWN_D) ? OWN_I : OWN_D;
                  else                      own = d_req[k] ? OWN_D : OWN_I;
                  act[k] = 1'b1; g[k] = cyc; owner[k] = own; last[k] = own;
                  if (own == OWN_D) begin
                     maddr[k] = d_addr[k]; mwe[k] = d_we[k]; mwd[k] = d_wdata[k];
                  end else begin
                     maddr[k] = i_addr[k]; mwe[k] = 1'b0;    mwd[k] = '0;
                  end
                  emad[k] = maddr[k];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Requester tasks: called just after a rising edge, hold req until the
   // valid pulse, drop req at the edge ending the valid cycle.
   // ------------------------------------------------------------------------
   task automatic do_fetch(input int k, input logic [31:0] a, output logic [31:0] rd, output int lat);
      int t0;
      bit seen;
      i_req[k] = 1'b1; i_addr[k] = a;
      t0 = cyc; seen = 1'b0; rd = '0; lat = -1;
      for (int n = 0; n < 60 && !seen; n++) begin
         @(negedge clk);
         if (i_valid[k] === 1'b1) begin seen = 1'b1; lat = cyc - t0; rd = i_rdata[k]; end
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL k%0d fetch_timeout addr=%h actual=no_valid required=valid", k, a);
      end
      @(posedge clk); #1;
      i_req[k] = 1'b0;
   endtask

   task automatic do_data(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
      int t0;
      bit seen;
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd;
      t0 = cyc; seen = 1'b0; rd = '0; lat = -1;
      for (int n = 0; n < 60 && !seen; n++) begin
         @(negedge clk);
         if (d_valid[k] === 1'b1) begin seen = 1'b1; lat = cyc - t0; rd = d_rdata[k]; end
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL k%0d data_timeout addr=%h actual=no_valid required=valid", k, a);
      end
      @(posedge clk); #1;
      d_req[k] = 1'b0;
   endtask

   task automatic clear_logs(input int k);
      aq[k].delete(); ac[k].delete(); vq[k].delete(); vc[k].delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      logic [31:0] rd0, rd1, rd2, rd3;
      int          l0, l1, l2, l3, r;
      logic [31:0] exp_addr [4];
      exp_addr = '{32'h100, 32'h200, 32'h104, 32'h204};

      for (int k = 0; k < 2; k++) begin
         reset[k] = 1'b1; i_req[k] = 1'b0; i_addr[k] = '0;
         d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
         mem_rdata[k] = '0; due[k] = -1;
      end
      mem[{1'b0, 32'h10}] = 32'h2402_000A;
      mem[{1'b1, 32'h30}] = 32'h1122_3344;

      // reset with both requests pending
      i_req[0] = 1'b1; d_req[0] = 1'b1; i_addr[0] = 32'h10; d_addr[0] = 32'h20;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      chkb(0, "rst_mem_en",  mem_en[0],  1'b0);
      chkb(0, "rst_mem_we",  mem_we[0],  1'b0);
      chkb(0, "rst_i_valid", i_valid[0], 1'b0);
      chkb(0, "rst_d_valid", d_valid[0], 1'b0);
      chkb(0, "rst_busy",    busy[0],    1'b0);
      chk (0, "rst_mem_addr",  mem_addr[0],  32'h0);
      chk (0, "rst_mem_wdata", mem_wdata[0], 32'h0);
      chk (0, "rst_i_rdata",   i_rdata[0],   32'h0);
      chk (0, "rst_d_rdata",   d_rdata[0],   32'h0);
      @(posedge clk); #1;
      reset[0] = 1'b0; reset[1] = 1'b0; r = cyc;
      clear_logs(0);
      fork
         do_fetch(0, 32'h10, rd0, l0);
         do_data (0, 1'b0, 32'h20, 32'h0, rd1, l1);
      join
      chk(0, "first_grant_addr", aq[0].size() > 0 ? aq[0][0] : 32'hFFFF_FFFF, 32'h10);
      chk(0, "first_strobe_delay", ac[0].size() > 0 ? ac[0][0] - r : -1, 1);
      chk(0, "first_fetch_lat", l0, 3);
      chk(0, "first_fetch_data", rd0, 32'h2402_000A);
      chk(0, "second_data_lat", l1, 7);
      chk(0, "second_data_rd", rd1, 32'h5A00_0020);

      // single fetch
      do_fetch(0, 32'h10, rd0, l0);
      chk(0, "fetch_lat", l0, 3);
      chk(0, "fetch_data", rd0, 32'h2402_000A);

      // write then read back
      do_data(0, 1'b1, 32'h40, 32'hDEAD_BEEF, rd1, l1);
      chk(0, "write_lat", l1, 3);
      do_data(0, 1'b0, 32'h40, 32'h0, rd1, l1);
      chk(0, "read_lat", l1, 3);
      chk(0, "read_back", rd1, 32'hDEAD_BEEF);
      chk(0, "i_rdata_kept", i_rdata[0], 32'h2402_000A);

      // continuous contention
      clear_logs(0);
      fork
         begin do_fetch(0, 32'h100, rd0, l0); do_fetch(0, 32'h104, rd1, l1); end
         begin do_data(0, 1'b0, 32'h200, 32'h0, rd2, l2); do_data(0, 1'b0, 32'h204, 32'h0, rd3, l3); end
      join
      chk(0, "cont_strobes", aq[0].size(), 4);
      chk(0, "cont_valids",  vq[0].size(), 4);
      for (int i = 0; i < 4 && i < aq[0].size(); i++) chk(0, "cont_addr_order", aq[0][i], exp_addr[i]);
      for (int i = 0; i < 4 && i < vq[0].size(); i++) chkb(0, "cont_owner_order", vq[0][i], (i % 2 == 0) ? OWN_I : OWN_D);
      for (int i = 0; i + 1 < vc[0].size(); i++) chk(0, "cont_valid_spacing", vc[0][i+1] - vc[0][i], 4);

      // reset during the WAIT of a data read
      clear_logs(0);
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h40;
      @(posedge clk); #1;      // ACCESS
      @(posedge clk); #1;      // WAIT
      reset[0] = 1'b1; i_req[0] = 1'b1; i_addr[0] = 32'h10;
      @(posedge clk); #1;
      reset[0] = 1'b0;
      fork
         do_fetch(0, 32'h10, rd0, l0);
         do_data (0, 1'b0, 32'h44, 32'h0, rd1, l1);
      join
      chk (0, "rstw_valid_count", vq[0].size(), 2);
      chkb(0, "rstw_first_valid", vq[0].size() > 0 ? vq[0][0] : OWN_D, OWN_I);
      chk (0, "rstw_regrant_addr", aq[0].size() > 1 ? aq[0][1] : 32'hFFFF_FFFF, 32'h10);
      chk (0, "rstw_fetch_data", rd0, 32'h2402_000A);
      chk (0, "rstw_data_rd", rd1, 32'h5A00_0044);

      // LATENCY = 3 instance
      do_fetch(1, 32'h30, rd0, l0);
      chk(1, "l3_fetch_lat", l0, 5);
      chk(1, "l3_fetch_data", rd0, 32'h1122_3344);
      do_data(1, 1'b1, 32'h34, 32'hCAFE_F00D, rd1, l1);
      chk(1, "l3_write_lat", l1, 5);
      do_data(1, 1'b0, 32'h34, 32'h0, rd1, l1);
      chk(1, "l3_read_lat", l1, 5);
      chk(1, "l3_read_back", rd1, 32'hCAFE_F00D);
      chk(1, "l3_i_rdata_kept", i_rdata[1], 32'h1122_3344);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
